uc_seq: RTL and testbench
=========================

UC_SEQ -- requirements
Module: uc_seq

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; forces state S_BOOT and clears every counter.
REQ-003 run  input  1  start/resume request; sampled in S_IDLE only.
REQ-004 Opcode  input  6  instruction bits [15:10] from the datapath.
REQ-005 zero  input  1  registered zero flag from the datapath.
REQ-006 s_inc  output  1  PC mux select; 1 = PC+1, 0 = jump address.
REQ-007 s_inm  output  1  1 = immediate operand and register-address path; 0 = register operand.
REQ-008 we  output  1  register-file write enable.
REQ-009 wez  output  1  zero-flag write enable.
REQ-010 ALUOp  output  3  ALU operation code.
REQ-011 pc_en  output  1  PC register load enable; the PC holds when 0.
REQ-012 halted  output  1  high while in S_HALT.
REQ-013 illegal  output  1  sticky flag, set on an undefined opcode.

Function
REQ-014 The block SHALL use the states S_BOOT, S_IDLE, S_RUN, S_WAIT and S_HALT, with a 4-bit wait counter.
REQ-015 Outside S_RUN, the outputs SHALL be s_inc=1, s_inm=0, we=0, wez=0, ALUOp=000 and pc_en=0.
REQ-016 S_BOOT SHALL last exactly one cycle, to cover the synchronous program-memory latency, then move to S_IDLE.
REQ-017 S_IDLE SHALL move to S_RUN on the first edge with run=1.
REQ-018 In S_RUN, decode SHALL be purely combinational from Opcode and zero, with zero-cycle latency; pc_en=1 unless stated otherwise.
REQ-019 Opcode[5]=1 (ALU register op): ALUOp=Opcode[4:2], s_inm=0, we=1, wez=1, s_inc=1.
REQ-020 Opcode[5:2]=0000 (load immediate): s_inm=1, ALUOp=000, we=1, wez=0, s_inc=1.
REQ-021 000100 (J): s_inc=0, we=0, wez=0.
REQ-022 000101 (JZ): s_inc=~zero, we=0, wez=0.
REQ-023 000110 (JNZ): s_inc=zero, we=0, wez=0.
REQ-024 000111 (HALT): pc_en=0, we=0; next state S_HALT.
REQ-025 001000 (NOP): s_inc=1, we=0, wez=0.
REQ-026 0011nn (WAIT): pc_en=0 for the decode cycle; load the counter with 4*(nn+1)-1; next state S_WAIT.
REQ-027 In S_WAIT, the counter SHALL decrement each cycle; when it equals 0, pc_en=1 and s_inc=1 for that cycle and the next state is S_RUN. Total PC hold = 4*(nn+1) cycles.
REQ-028 All other opcodes (001001-001011 and 01xxxx) SHALL execute as NOP and set illegal=1; illegal stays set until reset.
REQ-029 S_HALT SHALL be absorbing; only reset exits it; run is ignored.
REQ-030 run=0 in S_RUN or S_WAIT SHALL have no effect; execution does not pause.
REQ-031 An ALU op with wez=1 followed by JZ SHALL use the zero value updated by that ALU op; no bypass logic is needed.
REQ-032 WAIT with nn=11 SHALL hold the PC 16 cycles and the counter SHALL not wrap.

Reset
REQ-033 Asserting reset in any state, including mid-WAIT or in S_HALT, SHALL immediately force S_BOOT, counter=0, illegal=0, halted=0 and all outputs to the REQ-015 values.
REQ-034 After reset deasserts, the first pc_en=1 SHALL occur no earlier than two edges later (S_BOOT, then S_IDLE with run=1).

Verification
REQ-035 Reset, then run=1 at the second edge, then Opcode=100100 -> S_RUN; ALUOp=001, we=1, wez=1, s_inc=1, pc_en=1.
REQ-036 Opcode=000101 with zero=1 -> s_inc=0; with zero=0 -> s_inc=1; we=0 in both cases.
REQ-037 Opcode=001101 (WAIT, nn=01) -> pc_en=0 for 8 consecutive cycles, then pc_en=1 with the next opcode decoded.
REQ-038 Opcode=000111 -> halted=1 from the next cycle; with run toggling for 20 cycles, pc_en stays 0; reset then clears halted.
REQ-039 Opcode=010010 -> behaves as NOP (we=0, s_inc=1) and illegal=1 stays set through later legal opcodes until reset.
REQ-040 Reset asserted 3 cycles into a WAIT with nn=11 -> same-cycle return to the REQ-015 outputs; after release, S_BOOT is followed by S_IDLE.

Source files
------------

// File: rtl/uc_seq_if.sv
// Sequencer bus between the datapath and the uc_seq control unit.
//   run     : start/resume request (datapath/host -> sequencer)
//   Opcode  : instruction bits [15:10]
//   zero    : registered zero flag from the datapath
//   s_inc   : PC mux select, 1 = PC+1, 0 = jump address
//   s_inm   : 1 = immediate operand / register-address path
//   we, wez : register-file and zero-flag write enables
//   ALUOp   : ALU operation code
//   pc_en   : PC load enable
//   halted  : sequencer sits in the halt state
//   illegal : sticky undefined-opcode flag
interface uc_seq_if;
    logic       run;
    logic [5:0] Opcode;
    logic       zero;
    logic       s_inc;
    logic       s_inm;
    logic       we;
    logic       wez;
    logic [2:0] ALUOp;
    logic       pc_en;
    logic       halted;
    logic       illegal;

    modport master (
        output run, Opcode, zero,
        input  s_inc, s_inm, we, wez, ALUOp, pc_en, halted, illegal
    );

    modport slave (
        input  run, Opcode, zero,
        output s_inc, s_inm, we, wez, ALUOp, pc_en, halted, illegal
    );
endinterface

// File: rtl/uc_seq.sv
// uc_seq: microcontroller control sequencer.
// Boots for one cycle, idles until run, then decodes each instruction
// combinationally (zero-cycle latency) into datapath controls. Supports
// jumps, halt, a multi-cycle WAIT that holds the PC for 4*(nn+1) cycles,
// and a sticky flag for undefined opcodes.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; returns to boot and clears counters
//   bus   : uc_seq_if.slave carrying run/Opcode/zero in, controls out
module uc_seq (
    input  logic     clk,
    input  logic     reset,
    uc_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_IDLE = 3'd1,
        S_RUN  = 3'd2,
        S_WAIT = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       illegal_q, illegal_d;

    logic       s_inc_s;
    logic       s_inm_s;
    logic       we_s;
    logic       wez_s;
    logic [2:0] alu_op_s;
    logic       pc_en_s;

    // State register, wait counter and sticky illegal flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_BOOT;
            cnt_q     <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic and combinational instruction decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        s_inc_s   = 1'b1;
        s_inm_s   = 1'b0;
        we_s      = 1'b0;
        wez_s     = 1'b0;
        alu_op_s  = 3'b000;
        pc_en_s   = 1'b0;
        case (state_q)
            S_BOOT: begin
                // One cycle to cover the synchronous program-memory read.
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (bus.run) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                pc_en_s = 1'b1;
                casez (bus.Opcode)
                    6'b1?????: begin
                        alu_op_s = bus.Opcode[4:2];
                        we_s     = 1'b1;
                        wez_s    = 1'b1;
                    end
                    6'b0000??: begin
                        s_inm_s = 1'b1;
                        we_s    = 1'b1;
                    end
                    6'b000100: begin
                        s_inc_s = 1'b0;
                    end
                    6'b000101: begin
                        s_inc_s = ~bus.zero;
                    end
                    6'b000110: begin
                        s_inc_s = bus.zero;
                    end
                    6'b000111: begin
                        pc_en_s = 1'b0;
                        state_d = S_HALT;
                    end
                    6'b001000: begin
                        s_inc_s = 1'b1;
                    end
                    6'b0011??: begin
                        // Decode cycle is the first hold cycle, so the
                        // counter starts at 4*(nn+1)-1 = {nn, 2'b11}.
                        pc_en_s = 1'b0;
                        cnt_d   = {bus.Opcode[1:0], 2'b11};
                        state_d = S_WAIT;
                    end
                    default: begin
                        // Undefined opcode: behaves as NOP, flag sticks.
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    pc_en_s = 1'b1;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    assign bus.s_inc   = s_inc_s;
    assign bus.s_inm   = s_inm_s;
    assign bus.we      = we_s;
    assign bus.wez     = wez_s;
    assign bus.ALUOp   = alu_op_s;
    assign bus.pc_en   = pc_en_s;
    assign bus.halted  = (state_q == S_HALT);
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_uc_seq.sv
// Self-checking bench for uc_seq: directed steps followed by random
// opcodes, compared against a phase/hold-count reference model.
module tb_uc_seq;
    logic clk = 1'b0;
    logic reset;

    uc_seq_if bus ();

    uc_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam int P_BOOT = 0;
    localparam int P_IDLE = 1;
    localparam int P_RUN  = 2;
    localparam int P_HOLD = 3;
    localparam int P_HALT = 4;

    int m_phase;
    int m_held;
    int m_target;
    bit m_ill;

    int checks   = 0;
    int failures = 0;

    logic [9:0] o;
    int         n_hold;
    int         guard;

    // Expected {s_inc,s_inm,we,wez,ALUOp,pc_en,halted,illegal}.
    function automatic logic [9:0] model_out(input int op, input bit z);
        bit inc;
        bit inm;
        bit w;
        bit wz;
        bit pe;
        int alu;
        logic [2:0] alu3;
        inc = 1'b1; inm = 1'b0; w = 1'b0; wz = 1'b0; pe = 1'b0; alu = 0;
        if (m_phase == P_HOLD && m_held == m_target) pe = 1'b1;
        if (m_phase == P_RUN) begin
            pe = 1'b1;
            if (op >= 32) begin
                alu = (op / 4) % 8; w = 1'b1; wz = 1'b1;
            end else if (op < 4) begin
                inm = 1'b1; w = 1'b1;
            end else if (op == 4) begin
                inc = 1'b0;
            end else if (op == 5) begin
                inc = !z;
            end else if (op == 6) begin
                inc = z;
            end else if (op == 7) begin
                pe = 1'b0;
            end else if (op >= 12 && op <= 15) begin
                pe = 1'b0;
            end
        end
        alu3 = alu[2:0];
        return {inc, inm, w, wz, alu3, pe, (m_phase == P_HALT), m_ill};
    endfunction

    task automatic model_step(input int op, input bit r);
        case (m_phase)
            P_BOOT: m_phase = P_IDLE;
            P_IDLE: if (r) m_phase = P_RUN;
            P_RUN: begin
                if (op == 7) begin
                    m_phase = P_HALT;
                end else if (op >= 12 && op <= 15) begin
                    m_target = 4 * (op - 12 + 1);
                    m_held   = 1;
                    m_phase  = P_HOLD;
                end else if ((op >= 9 && op <= 11) || (op >= 16 && op <= 31)) begin
                    m_ill = 1'b1;
                end
            end
            P_HOLD: begin
                if (m_held == m_target) m_phase = P_RUN;
                else m_held = m_held + 1;
            end
            default: m_phase = P_HALT;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] dut_out();
        return {bus.s_inc, bus.s_inm, bus.we, bus.wez, bus.ALUOp,
                bus.pc_en, bus.halted, bus.illegal};
    endfunction

    // One clock: drive inputs, compare mid-cycle, advance model at the edge.
    task automatic cycle(input bit r, input logic [5:0] op, input bit z,
                         input string tag, output logic [9:0] obs);
        bus.run = r; bus.Opcode = op; bus.zero = z;
        @(negedge clk);
        obs = dut_out();
        check(tag, 32'(obs), 32'(model_out(int'(op), z)));
        @(posedge clk);
        model_step(int'(op), r);
        #1;
    endtask

    // Assert reset mid-cycle; outputs must return to idle values at once.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        m_phase = P_BOOT; m_ill = 1'b0; m_held = 0; m_target = 0;
        check(tag, 32'(dut_out()), 32'(model_out(int'(bus.Opcode), bus.zero)));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.run = 1'b0; bus.Opcode = 6'b000000; bus.zero = 1'b0;
        m_phase = P_BOOT; m_ill = 1'b0; m_held = 0; m_target = 0;
        #3;
        check("reset_state", 32'(dut_out()), 32'(10'b1_0_0_0_000_0_0_0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Boot, then idle sees run, then the first ALU op runs.
        cycle(1'b0, 6'b100100, 1'b0, "boot", o);
        check("boot_pc_en", 32'(o[2]), 32'd0);
        cycle(1'b1, 6'b100100, 1'b0, "idle_run", o);
        check("idle_pc_en", 32'(o[2]), 32'd0);
        cycle(1'b1, 6'b100100, 1'b0, "alu_op", o);
        check("alu_op_fields", 32'(o), 32'(10'b1_0_1_1_001_1_0_0));

        // JZ in both zero states, with run low (no pause in run).
        cycle(1'b0, 6'b000101, 1'b1, "jz_taken", o);
        check("jz_taken_s_inc", 32'(o[9]), 32'd0);
        cycle(1'b0, 6'b000101, 1'b0, "jz_fall", o);
        check("jz_fall_s_inc", 32'(o[9]), 32'd1);
        cycle(1'b0, 6'b000110, 1'b1, "jnz_fall", o);
        cycle(1'b0, 6'b000110, 1'b0, "jnz_taken", o);
        cycle(1'b1, 6'b000100, 1'b0, "jump", o);
        cycle(1'b1, 6'b000010, 1'b0, "load_imm", o);
        check("load_imm_fields", 32'(o), 32'(10'b1_1_1_0_000_1_0_0));
        cycle(1'b1, 6'b001000, 1'b0, "nop", o);
        cycle(1'b1, 6'b111111, 1'b0, "alu_op7", o);

        // WAIT nn=01: eight hold cycles, then release.
        n_hold = 0; guard = 0;
        do begin
            cycle(1'b1, 6'b001101, 1'b0, "wait1", o);
            if (o[2] == 1'b0) n_hold++;
            guard++;
        end while (o[2] == 1'b0 && guard < 40);
        check("wait1_hold", 32'(n_hold), 32'd8);
        cycle(1'b1, 6'b101000, 1'b0, "after_wait", o);
        check("after_wait_pc_en", 32'(o[2]), 32'd1);

        // Illegal opcode acts as NOP and the flag sticks.
        cycle(1'b1, 6'b010010, 1'b0, "illegal_op", o);
        check("illegal_nop_we", 32'(o[7]), 32'd0);
        cycle(1'b1, 6'b100000, 1'b1, "post_ill1", o);
        cycle(1'b1, 6'b001000, 1'b1, "post_ill2", o);
        check("illegal_sticky", 32'(o[0]), 32'd1);

        // WAIT nn=11: sixteen hold cycles, counter must not wrap.
        n_hold = 0; guard = 0;
        do begin
            cycle(1'b0, 6'b001111, 1'b0, "wait3", o);
            if (o[2] == 1'b0) n_hold++;
            guard++;
        end while (o[2] == 1'b0 && guard < 40);
        check("wait3_hold", 32'(n_hold), 32'd16);

        // Reset three cycles into a long WAIT.
        cycle(1'b1, 6'b001111, 1'b0, "wait3b_dec", o);
        cycle(1'b1, 6'b001111, 1'b0, "wait3b_h1", o);
        cycle(1'b1, 6'b001111, 1'b0, "wait3b_h2", o);
        do_reset("reset_mid_wait");
        cycle(1'b0, 6'b100100, 1'b0, "boot2", o);
        cycle(1'b0, 6'b100100, 1'b0, "idle_hold", o);
        cycle(1'b1, 6'b100100, 1'b0, "idle_run2", o);
        check("idle_run2_pc_en", 32'(o[2]), 32'd0);
        cycle(1'b1, 6'b110100, 1'b0, "alu_op5", o);
        check("alu_op5_fields", 32'(o), 32'(10'b1_0_1_1_101_1_0_0));

        // Reset while an ALU op is active: we must drop immediately.
        do_reset("reset_mid_alu");
        cycle(1'b1, 6'b000000, 1'b0, "boot3", o);
        cycle(1'b1, 6'b000000, 1'b0, "idle3", o);

        // HALT is absorbing; run toggling does nothing.
        cycle(1'b1, 6'b000111, 1'b0, "halt_dec", o);
        check("halt_dec_pc_en", 32'(o[2]), 32'd0);
        for (int i = 0; i < 20; i++) begin
            cycle(i[0], 6'b100100, 1'b0, "halted", o);
            check("halted_flag", 32'({o[2], o[1]}), 32'b01);
        end
        do_reset("reset_halt");
        check("halt_cleared", 32'(bus.halted), 32'd0);
        cycle(1'b1, 6'b000000, 1'b0, "boot4", o);

        // Random opcodes, run and zero against the reference model.
        for (int i = 0; i < 800; i++) begin
            int op;
            bit z;
            bit r;
            logic [5:0] op6;
            op = int'($urandom_range(0, 63));
            if (op == 7 && $urandom_range(0, 3) != 0) op = 8;
            z  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            op6 = op[5:0];
            if ((m_phase == P_HALT && $urandom_range(0, 5) == 0) ||
                $urandom_range(0, 149) == 0) begin
                do_reset("rand_reset");
            end else begin
                cycle(r, op6, z, "rand", o);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
